// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM states, redirect
// source encoding and default PC constants.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ       = 3'd0,
        SRC_STALL     = 3'd1,
        SRC_BRANCH    = 3'd2,
        SRC_JALR      = 3'd3,
        SRC_TRAP      = 3'd4,
        SRC_BREAK     = 3'd5,
        SRC_RESUME    = 3'd6,
        SRC_HALT_HOLD = 3'd7
    } src_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    function automatic logic src_loads_pc(input src_t s);
        return !(s inside {SRC_STALL, SRC_BREAK, SRC_HALT_HOLD});
    endfunction

    // Sources that count as a taken control-flow redirect.
    function automatic logic src_is_redirect(input src_t s);
        return s inside {SRC_BRANCH, SRC_JALR, SRC_TRAP};
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational next-PC priority select: sys_req > jalr > branch > stall > sequential,
// masked by the sequencer state. Produces target PC, source code and flush pattern.
module pc_redirect_arb
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  state_t      state,
    input  logic [31:0] pc,
    input  logic [31:0] pc_inc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jalr_req,
    input  logic [31:0] jalr_target,
    input  logic        sys_req,
    input  logic        sys_is_break,
    input  logic        resume,
    output logic [31:0] next_pc,
    output src_t        src,
    output logic        if_id_flush,
    output logic        id_ex_flush
);

    logic [31:0] target_pc;

    always_comb begin
        target_pc   = pc_inc;
        src         = SRC_SEQ;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (state == HALT) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (resume) begin
                src       = SRC_RESUME;
                target_pc = pc + 32'd4;
            end else begin
                src       = SRC_HALT_HOLD;
                target_pc = pc;
            end
        end else if (sys_req) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (sys_is_break) begin
                src       = SRC_BREAK;
                target_pc = pc;
            end else begin
                src       = SRC_TRAP;
                target_pc = TRAP_VEC;
            end
        end else if (state == FLUSH) begin
            // Branch/JALR seen here belong to squashed instructions.
            if_id_flush = 1'b1;
        end else if (jalr_req) begin
            src         = SRC_JALR;
            target_pc   = jalr_target;
            if_id_flush = 1'b1;
        end else if (br_taken) begin
            src         = SRC_BRANCH;
            target_pc   = br_target;
            if_id_flush = 1'b1;
        end else if (stall) begin
            src       = SRC_STALL;
            target_pc = pc;
        end
    end

    assign next_pc = {target_pc[31:1], 1'b0};

endmodule

// File: rtl/register.sv
// Generic loadable register with asynchronous active-low reset.
module register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer with RUN/FLUSH/HALT FSM and IF/ID, ID/EX flush strobes.
// Optional taken-redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VEC     = DEFAULT_TRAP_VEC,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pc_inc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jalr_req,
    input  logic [31:0] jalr_target,
    input  logic        sys_req,
    input  logic        sys_is_break,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    localparam logic [1:0]  FLUSH_LOAD   = 2'(FLUSH_CYCLES - 1);
    localparam logic [31:0] RESET_PC_ALN = RESET_PC & ~32'd1;

    state_t      state_reg, state_next;
    logic [1:0]  flush_cnt_reg, flush_cnt_next;
    logic        halted_reg;
    logic [31:0] next_pc;
    src_t        src;
    logic        pc_load;

    pc_redirect_arb #(
        .TRAP_VEC(TRAP_VEC)
    ) u_arb (
        .state       (state_reg),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jalr_req    (jalr_req),
        .jalr_target (jalr_target),
        .sys_req     (sys_req),
        .sys_is_break(sys_is_break),
        .resume      (resume),
        .next_pc     (next_pc),
        .src         (src),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush)
    );

    assign pc_load = src_loads_pc(src);

    register #(
        .WIDTH    (32),
        .RESET_VAL(RESET_PC_ALN)
    ) u_pc_reg (
        .clk  (clk),
        .rst_n(rst),
        .load (pc_load),
        .d    (next_pc),
        .q    (pc)
    );

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (src)
            SRC_TRAP, SRC_BRANCH, SRC_JALR: begin
                state_next     = FLUSH;
                flush_cnt_next = FLUSH_LOAD;
            end
            SRC_BREAK:  state_next = HALT;
            SRC_RESUME: state_next = RUN;
            default: begin
                if (state_reg == FLUSH) begin
                    if (flush_cnt_reg == 2'd0) begin
                        state_next = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg - 2'd1;
                    end
                end else if (state_reg != HALT) begin
                    // Also recovers the unused encoding.
                    state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 2'd0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            halted_reg    <= (state_next == HALT);
        end
    end

    assign halted = halted_reg;

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_reg <= 16'd0;
        end else if (src_is_redirect(src) && (redirect_cnt_reg != 16'hFFFF)) begin
            redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
`else
    assign redirect_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (optionally with PC_REDIRECT_CNT_EN).
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_inc;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jalr_req = 1'b0;
    logic [31:0] jalr_target = '0;
    logic        sys_req = 1'b0;
    logic        sys_is_break = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb pc_inc = pc + 32'd4;

    pc_redirect_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_inc      (pc_inc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jalr_req    (jalr_req),
        .jalr_target (jalr_target),
        .sys_req     (sys_req),
        .sys_is_break(sys_is_break),
        .resume      (resume),
        .pc          (pc),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .halted      (halted),
        .redirect_cnt(redirect_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (pc !== 32'h0) begin
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); failures++;
        end
        checks++;
        if ({halted, if_id_flush, id_ex_flush} !== 3'b000) begin
            $display("FAIL reset_flags got=%b exp=000", {halted, if_id_flush, id_ex_flush}); failures++;
        end
        checks++;
        if (redirect_cnt !== 16'd0) begin
            $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); failures++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        $display("reset released pc=%h", pc);
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            checks++;
            if (pc !== exp_pc || if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin
                $display("FAIL seq_step%0d got pc=%h fl=%b%b exp pc=%h fl=00",
                         i, pc, if_id_flush, id_ex_flush, exp_pc); failures++;
            end
            $display("seq step %0d pc=%h", i, pc);
            tick();
        end
    endtask

    task automatic test_branch;
        // pc is 0x10 here
        br_taken = 1'b1; br_target = 32'h40;
        #1;
        checks++;
        if (pc !== 32'h10 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b0) begin
            $display("FAIL br_req got pc=%h fl=%b%b exp pc=00000010 fl=10", pc, if_id_flush, id_ex_flush); failures++;
        end
        tick();
        checks++;
        if (pc !== 32'h40) begin
            $display("FAIL br_target got=%h exp=00000040", pc); failures++;
        end
        br_target = 32'h200;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b0) begin
            $display("FAIL br_flush_cycle got fl=%b%b exp=10", if_id_flush, id_ex_flush); failures++;
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h44 || if_id_flush !== 1'b0) begin
            $display("FAIL br_ignored_in_flush got pc=%h ifid=%b exp pc=00000044 ifid=0", pc, if_id_flush); failures++;
        end
        $display("branch done pc=%h", pc);
    endtask

    task automatic test_jalr_vs_branch;
        jalr_req = 1'b1; jalr_target = 32'h81;
        br_taken = 1'b1; br_target = 32'h20;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b0) begin
            $display("FAIL jalr_flush got fl=%b%b exp=10", if_id_flush, id_ex_flush); failures++;
        end
        tick();
        jalr_req = 1'b0; br_taken = 1'b0;
        checks++;
        if (pc !== 32'h80) begin
            $display("FAIL jalr_target got=%h exp=00000080", pc); failures++;
        end
        tick();
        checks++;
        if (pc !== 32'h84) begin
            $display("FAIL jalr_after_flush got=%h exp=00000084", pc); failures++;
        end
        $display("jalr done pc=%h", pc);
    endtask

    task automatic test_ecall_stall;
        sys_req = 1'b1; sys_is_break = 1'b0; stall = 1'b1;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
            $display("FAIL ecall_flush got fl=%b%b exp=11", if_id_flush, id_ex_flush); failures++;
        end
        tick();
        sys_req = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h100 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b0) begin
            $display("FAIL ecall_target got pc=%h fl=%b%b exp pc=00000100 fl=10", pc, if_id_flush, id_ex_flush); failures++;
        end
        tick();
        checks++;
        if (pc !== 32'h104) begin
            $display("FAIL ecall_after_flush got=%h exp=00000104", pc); failures++;
        end
        $display("ecall done pc=%h", pc);
    endtask

    task automatic test_ebreak_resume;
        br_taken = 1'b1; br_target = 32'h20;
        tick();
        br_taken = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h24) begin
            $display("FAIL ebreak_setup got=%h exp=00000024", pc); failures++;
        end
        sys_req = 1'b1; sys_is_break = 1'b1;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || halted !== 1'b0) begin
            $display("FAIL ebreak_req got fl=%b%b halted=%b exp fl=11 halted=0", if_id_flush, id_ex_flush, halted); failures++;
        end
        tick();
        sys_req = 1'b0; sys_is_break = 1'b0;
        br_taken = 1'b1; br_target = 32'h300; jalr_req = 1'b1; jalr_target = 32'h400;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (pc !== 32'h24 || halted !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
                $display("FAIL halt_hold%0d got pc=%h halted=%b fl=%b%b exp pc=00000024 halted=1 fl=11",
                         i, pc, halted, if_id_flush, id_ex_flush); failures++;
            end
            tick();
        end
        br_taken = 1'b0; jalr_req = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if (pc !== 32'h28 || halted !== 1'b0) begin
            $display("FAIL resume got pc=%h halted=%b exp pc=00000028 halted=0", pc, halted); failures++;
        end
        $display("ebreak/resume done pc=%h", pc);
    endtask

    task automatic test_stall;
        stall = 1'b1; resume = 1'b1;
        #1;
        checks++;
        if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin
            $display("FAIL stall_flush got fl=%b%b exp=00", if_id_flush, id_ex_flush); failures++;
        end
        tick();
        resume = 1'b0;
        checks++;
        if (pc !== 32'h28 || halted !== 1'b0) begin
            $display("FAIL stall_resume_hold got pc=%h halted=%b exp pc=00000028 halted=0", pc, halted); failures++;
        end
        br_taken = 1'b1; br_target = 32'h61;
        #1;
        checks++;
        if (if_id_flush !== 1'b1) begin
            $display("FAIL stall_br_flush got=%b exp=1", if_id_flush); failures++;
        end
        tick();
        br_taken = 1'b0; stall = 1'b0;
        checks++;
        if (pc !== 32'h60) begin
            $display("FAIL stall_br_target got=%h exp=00000060", pc); failures++;
        end
        tick();
        checks++;
        if (pc !== 32'h64) begin
            $display("FAIL stall_br_after got=%h exp=00000064", pc); failures++;
        end
        $display("stall done pc=%h", pc);
    endtask

    task automatic test_reset_mid_halt;
        sys_req = 1'b1; sys_is_break = 1'b1;
        tick();
        sys_req = 1'b0; sys_is_break = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc !== 32'h64) begin
            $display("FAIL mid_halt_setup got halted=%b pc=%h exp halted=1 pc=00000064", halted, pc); failures++;
        end
`ifdef PC_REDIRECT_CNT_EN
        checks++;
        if (redirect_cnt !== 16'd5) begin
            $display("FAIL redirect_count got=%0d exp=5", redirect_cnt); failures++;
        end
`endif
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || halted !== 1'b0 || redirect_cnt !== 16'd0 ||
            if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin
            $display("FAIL async_reset got pc=%h halted=%b cnt=%0d fl=%b%b exp pc=0 halted=0 cnt=0 fl=00",
                     pc, halted, redirect_cnt, if_id_flush, id_ex_flush); failures++;
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h4 || halted !== 1'b0) begin
            $display("FAIL post_reset_run got pc=%h halted=%b exp pc=00000004 halted=0", pc, halted); failures++;
        end
        $display("reset mid-halt done pc=%h", pc);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_vs_branch();
        test_ecall_stall();
        test_ebreak_resume();
        test_stall();
        test_reset_mid_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
